netdma_readmaster_ctrl: RTL
===========================

// Module: netdma_readmaster_ctrl
// PURPOSE
//  Descriptor sequencer for the netdma read master. Accepts one {address, length} descriptor at a time.
//  Drives the mm2st adapter's run/address/request controls and throttles outstanding reads.
//  Counts issued reads and received dataunits, and generates the packet eop/empty tags.
//  Sits between the CSR/descriptor front end and netdma_mm2st_adapter.
// PARAMETERS
//  DATA_WIDTH    64  datapath width in bits; NB = DATA_WIDTH/8, EW = $clog2(NB)
//  LENGTH_WIDTH  16  width of descriptor byte length
//  MAX_PENDING   16  max reads issued but not yet returned as dataunits (>=2)
// PORTS
//  clk_i             in   1             system clock
//  rst_n_i           in   1             asynchronous active-low reset
//  desc_valid_i      in   1             descriptor offered
//  desc_ready_o      out  1             descriptor accepted when valid&ready
//  desc_address_i    in   32            byte start address (low EW bits = offset)
//  desc_length_i     in   LENGTH_WIDTH  byte count
//  stop_i            in   1             abort current descriptor (level, sampled per clk)
//  run_posedge_o     out  1             1-cycle pulse, arms adapter sop
//  address_o         out  32            byte address of next read
//  run_requests_o    out  1             permit adapter to issue read
//  run_receive_o     out  1             descriptor active on receive side
//  new_pending_i     in   1             read accepted by slave this cycle
//  new_dataunit_i    in   1             dataunit written to adapter fifo this cycle
//  eop_o             out  1             current dataunit is last of packet
//  empty_o           out  EW            empty bytes in last dataunit
//  busy_o            out  1             state != IDLE
//  done_o            out  1             1-cycle pulse, descriptor finished
//  aborted_o         out  1             1-cycle pulse with done_o when ended by stop_i
//  len_err_o         out  1             1-cycle pulse, zero-length descriptor dropped
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, all counters 0. Reset mid-transfer discards everything with no done_o.
//  Accept handshake:
//   - desc_ready_o = (state==IDLE), combinational.
//   - On accept, latch addr and len.
//   - OFF = addr[EW-1:0].
//   - REQ_LEFT = ceil((OFF+len)/NB); UNITS_LEFT = ceil(len/NB).
//   - EMPTY = (NB - len%NB) % NB, held in a register.
//  len==0: len_err_o pulses the cycle after accept; state stays IDLE; no run_posedge_o.
//  FSM: IDLE -> ISSUE -> DRAIN -> IDLE.
//   - IDLE->ISSUE on accept with len!=0; run_posedge_o pulses in the first ISSUE cycle.
//   - ISSUE: run_requests_o = (REQ_LEFT!=0) & (OUTST<MAX_PENDING) & ~stop_i.
//   - ISSUE->DRAIN when REQ_LEFT reaches 0, or when stop_i is seen.
//   - DRAIN: run_requests_o=0. Goes to IDLE in the cycle after the last dataunit
//     (UNITS_LEFT==1 & new_dataunit_i), or when stopped and OUTST==0.
//  address_o:
//   - On accept: {addr[31:EW], OFF}.
//   - Each new_pending_i: upper bits += 1 word; OFF bits stay constant; 32-bit wrap allowed.
//  Counters:
//   - new_pending_i: REQ_LEFT-=1 (saturates at 0).
//   - new_dataunit_i: UNITS_LEFT-=1 (saturates at 0).
//   - OUTST: +1 on new_pending_i, -1 on new_dataunit_i; both in one cycle leaves it unchanged; floor 0.
//   - new_pending_i while REQ_LEFT==0, or new_dataunit_i in IDLE: ignored.
//  Tags:
//   - eop_o = busy & (UNITS_LEFT==1), combinational; sampled by adapter with new_dataunit_i.
//   - empty_o = EMPTY while eop_o, else 0.
//  run_receive_o: high in ISSUE and DRAIN, low in IDLE.
//  Completion: done_o pulses on the DRAIN->IDLE cycle; aborted_o pulses with it if stop_i was seen.
//  Stop path: eop_o is not forced; dataunits still in flight are drained.
//  stop_i in IDLE: ignored.
//  Throughput: back-to-back descriptors; desc_ready_o re-asserts the cycle done_o pulses.
// TESTING
//  1. NB=8, addr=0x1000, len=64: 8 reads at 0x1000..0x1038, 8 units, eop_o on unit 8, empty_o=0, done_o once.
//  2. addr=0x1003, len=13: REQ=2 (0x1003, 0x100B), UNITS=2, eop_o on unit 2 with empty_o=3.
//  3. MAX_PENDING=4, slave never returns data: run_requests_o drops after exactly 4 new_pending_i.
//     Resumes one read per returned dataunit.
//  4. len=0: len_err_o pulse, busy_o stays 0, no run_posedge_o, desc_ready_o stays 1.
//  5. stop_i after 3 of 10 reads with 2 outstanding: no further reads.
//     done_o+aborted_o the cycle after the 3rd dataunit.
//  6. rst_n_i low mid-DRAIN: all outputs 0 immediately; next descriptor runs cleanly from IDLE.

Source files
------------

// File: rtl/netdma_readmaster_ctrl.sv
// Descriptor sequencer for the netdma read master: walks one {address, length} descriptor at a time.
// Latency: run_posedge_o one cycle after accept; done_o one cycle after the last dataunit or stop drain.
// Backpressure: desc_ready_o only in IDLE; read requests held off at MAX_PENDING outstanding reads.
module netdma_readmaster_ctrl #(
  parameter int DATA_WIDTH   = 64,
  parameter int LENGTH_WIDTH = 16,
  parameter int MAX_PENDING  = 16,
  localparam int NB = DATA_WIDTH / 8,
  localparam int EW = $clog2(NB)
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    desc_valid_i,
  output logic                    desc_ready_o,
  input  logic [31:0]             desc_address_i,
  input  logic [LENGTH_WIDTH-1:0] desc_length_i,
  input  logic                    stop_i,
  output logic                    run_posedge_o,
  output logic [31:0]             address_o,
  output logic                    run_requests_o,
  output logic                    run_receive_o,
  input  logic                    new_pending_i,
  input  logic                    new_dataunit_i,
  output logic                    eop_o,
  output logic [EW-1:0]           empty_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    aborted_o,
  output logic                    len_err_o
);

  // Counters get one spare bit so that offset + length rounding cannot overflow.
  localparam int CW    = LENGTH_WIDTH + 1;
  localparam int OW    = $clog2(MAX_PENDING + 1);
  localparam int AW_HI = 32 - EW;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [31:0]   addr_q;
  logic [CW-1:0] req_left;
  logic [CW-1:0] units_left;
  logic [OW-1:0] outst;
  logic [OW-1:0] outst_nxt;
  logic [EW-1:0] empty_q;
  logic          stopped;
  logic          run_posedge_q;
  logic          done_q;
  logic          aborted_q;
  logic          len_err_q;

  logic          accept;
  logic          len_zero;
  logic          busy;
  logic          pend_acc;
  logic          unit_acc;
  logic          finish;
  logic [EW-1:0] off;
  logic [CW-1:0] req_init;
  logic [CW-1:0] unit_init;
  logic [EW-1:0] empty_init;

  assign desc_ready_o = (state == S_IDLE);
  assign accept       = desc_valid_i & desc_ready_o;
  assign len_zero     = (desc_length_i == '0);
  assign busy         = (state != S_IDLE);

  // Reads beyond the descriptor and dataunits outside a descriptor are ignored.
  assign pend_acc = busy & new_pending_i & (req_left != '0);
  assign unit_acc = busy & new_dataunit_i;

  // Read count covers the leading offset bytes; dataunit count and empty tag depend on length only.
  assign off        = desc_address_i[EW-1:0];
  assign req_init   = (CW'(desc_length_i) + CW'(off) + CW'(NB - 1)) >> EW;
  assign unit_init  = (CW'(desc_length_i) + CW'(NB - 1)) >> EW;
  assign empty_init = EW'(0) - desc_length_i[EW-1:0];

  // Outstanding-read count: a read and a dataunit in one cycle cancel; floor at 0, ceiling at MAX_PENDING.
  always_comb begin
    outst_nxt = outst;
    if (pend_acc && !unit_acc && (outst != OW'(MAX_PENDING))) begin
      outst_nxt = outst + OW'(1);
    end else if (!pend_acc && unit_acc && (outst != '0)) begin
      outst_nxt = outst - OW'(1);
    end
  end

  // Next-state logic; the stopped exit looks at the post-update outstanding count so the
  // descriptor ends right behind the final in-flight dataunit.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept && !len_zero) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (stop_i || (pend_acc && (req_left == CW'(1)))) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if ((unit_acc && (units_left == CW'(1))) || (stopped && (outst_nxt == '0))) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign finish = (state == S_DRAIN) && (state_nxt == S_IDLE);

  // State, abort flag and the single-cycle status pulses.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= S_IDLE;
      stopped       <= 1'b0;
      run_posedge_q <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      len_err_q     <= 1'b0;
    end else begin
      state         <= state_nxt;
      run_posedge_q <= accept & ~len_zero;
      len_err_q     <= accept & len_zero;
      done_q        <= finish;
      aborted_q     <= finish & stopped;
      if (accept) begin
        stopped <= 1'b0;
      end else if ((state == S_ISSUE) && stop_i) begin
        stopped <= 1'b1;
      end
    end
  end

  // Descriptor address and progress counters; the byte offset stays fixed while the word advances.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      addr_q     <= '0;
      req_left   <= '0;
      units_left <= '0;
      outst      <= '0;
      empty_q    <= '0;
    end else if (accept) begin
      addr_q     <= desc_address_i;
      req_left   <= req_init;
      units_left <= unit_init;
      outst      <= '0;
      empty_q    <= empty_init;
    end else begin
      outst <= outst_nxt;
      if (pend_acc) begin
        addr_q[31:EW] <= addr_q[31:EW] + AW_HI'(1);
        req_left      <= req_left - CW'(1);
      end
      if (unit_acc && (units_left != '0)) begin
        units_left <= units_left - CW'(1);
      end
    end
  end

  assign run_posedge_o  = run_posedge_q;
  assign address_o      = addr_q;
  assign run_requests_o = (state == S_ISSUE) && (req_left != '0) &&
                          (outst < OW'(MAX_PENDING)) && !stop_i;
  assign run_receive_o  = busy;
  assign busy_o         = busy;
  assign eop_o          = busy && (units_left == CW'(1));
  assign empty_o        = eop_o ? empty_q : '0;
  assign done_o         = done_q;
  assign aborted_o      = aborted_q;
  assign len_err_o      = len_err_q;

endmodule
